// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage_pipe
//  Description : RV64I decode stage. Splits the instruction, builds the
//                sign-extended immediate, forwards operands from NUM_FWD later
//                stages, stalls on load-use, and registers the decoded bundle
//                behind a valid/ready handshake with flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_stage_pipe #(
  parameter int XLEN    = 64,
  parameter int NUM_FWD = 3,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [31:0]            inst_i,
  input  logic [XLEN-1:0]        pc_i,
  output logic [4:0]             rs1_addr_o,
  output logic [4:0]             rs2_addr_o,
  input  logic [XLEN-1:0]        rs1_data_i,
  input  logic [XLEN-1:0]        rs2_data_i,
  input  logic [NUM_FWD*XLEN-1:0] fwd_wdata_i,
  input  logic [NUM_FWD*5-1:0]   fwd_rd_addr_i,
  input  logic [NUM_FWD-1:0]     fwd_wreg_i,
  input  logic [NUM_FWD-1:0]     fwd_pend_i,
  input  logic                   flush_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [6:0]             opcode_o,
  output logic [2:0]             funct3_o,
  output logic [6:0]             funct7_o,
  output logic [4:0]             rd_addr_o,
  output logic                   wreg_o,
  output logic [XLEN-1:0]        rs1_data_o,
  output logic [XLEN-1:0]        rs2_data_o,
  output logic [XLEN-1:0]        imm_o,
  output logic [XLEN-1:0]        pc_o,
  output logic [CNT_W-1:0]       stall_cnt_o
);

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_IMM32  = 7'b0011011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_OP     = 7'b0110011;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_OP32   = 7'b0111011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic [XLEN-1:0] w_fwd_data [NUM_FWD];
  logic [4:0]      w_fwd_rd   [NUM_FWD];

  logic [6:0]      w_opcode;
  logic [XLEN-1:0] w_rs1_data, w_rs2_data, w_imm;
  logic            w_rs1_pend, w_rs2_pend, w_rs1_used, w_rs2_used;
  logic            w_hazard, w_accept, w_wreg;

  logic            out_valid_q, out_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [6:0]      opcode_q, funct7_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_addr_q;
  logic            wreg_q;
  logic [XLEN-1:0] rs1_data_q, rs2_data_q, imm_q, pc_q;

  generate
    for (genvar k = 0; k < NUM_FWD; k++) begin : g_fwd_unpack
      assign w_fwd_data[k] = fwd_wdata_i[k*XLEN +: XLEN];
      assign w_fwd_rd[k]   = fwd_rd_addr_i[k*5 +: 5];
    end
  endgenerate

  assign w_opcode   = inst_i[6:0];
  assign rs1_addr_o = inst_i[19:15];
  assign rs2_addr_o = inst_i[24:20];

  // Operand select: scan oldest to youngest so the lowest matching slot wins; x0 is always zero.
  always_comb begin
    w_rs1_data = rs1_data_i;
    w_rs1_pend = 1'b0;
    w_rs2_data = rs2_data_i;
    w_rs2_pend = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_wreg_i[k] && (w_fwd_rd[k] == rs1_addr_o)) begin
        w_rs1_data = w_fwd_data[k];
        w_rs1_pend = fwd_pend_i[k];
      end
      if (fwd_wreg_i[k] && (w_fwd_rd[k] == rs2_addr_o)) begin
        w_rs2_data = w_fwd_data[k];
        w_rs2_pend = fwd_pend_i[k];
      end
    end
    if (rs1_addr_o == 5'd0) begin
      w_rs1_data = '0;
      w_rs1_pend = 1'b0;
    end
    if (rs2_addr_o == 5'd0) begin
      w_rs2_data = '0;
      w_rs2_pend = 1'b0;
    end
  end

  // Immediate generation and source-usage decode by opcode.
  always_comb begin
    w_imm      = '0;
    w_rs1_used = !((w_opcode == c_OP_LUI) || (w_opcode == c_OP_AUIPC) || (w_opcode == c_OP_JAL));
    w_rs2_used = (w_opcode == c_OP_OP) || (w_opcode == c_OP_OP32) ||
                 (w_opcode == c_OP_BRANCH) || (w_opcode == c_OP_STORE);
    case (w_opcode)
      c_OP_LOAD, c_OP_IMM, c_OP_IMM32, c_OP_JALR, c_OP_SYSTEM:
        w_imm = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
      c_OP_STORE:
        w_imm = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      c_OP_BRANCH:
        w_imm = {{(XLEN-13){inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      c_OP_LUI, c_OP_AUIPC:
        w_imm = {{(XLEN-32){inst_i[31]}}, inst_i[31:12], 12'b0};
      c_OP_JAL:
        w_imm = {{(XLEN-21){inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      default:
        w_imm = '0;
    endcase
  end

  assign w_wreg     = !((w_opcode == c_OP_BRANCH) || (w_opcode == c_OP_STORE) || (inst_i[11:7] == 5'd0));
  assign w_hazard   = in_valid_i && ((w_rs1_used && w_rs1_pend) || (w_rs2_used && w_rs2_pend));
  assign in_ready_o = !flush_i && !w_hazard && (!out_valid_q || out_ready_i);
  assign w_accept   = in_valid_i && in_ready_o;

  // Output-valid and stall-counter next state; flush dominates hold and accept.
  always_comb begin
    out_valid_d = out_valid_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (w_accept) begin
      out_valid_d = 1'b1;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
    stall_cnt_d = stall_cnt_q;
    if (w_hazard && !flush_i && (stall_cnt_q != c_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Pipeline register: bundle captured only on accept, otherwise held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      stall_cnt_q <= '0;
      opcode_q    <= '0;
      funct3_q    <= '0;
      funct7_q    <= '0;
      rd_addr_q   <= '0;
      wreg_q      <= 1'b0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      stall_cnt_q <= stall_cnt_d;
      if (w_accept) begin
        opcode_q   <= w_opcode;
        funct3_q   <= inst_i[14:12];
        funct7_q   <= inst_i[31:25];
        rd_addr_q  <= inst_i[11:7];
        wreg_q     <= w_wreg;
        rs1_data_q <= w_rs1_data;
        rs2_data_q <= w_rs2_data;
        imm_q      <= w_imm;
        pc_q       <= pc_i;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign stall_cnt_o = stall_cnt_q;
  assign opcode_o    = opcode_q;
  assign funct3_o    = funct3_q;
  assign funct7_o    = funct7_q;
  assign rd_addr_o   = rd_addr_q;
  assign wreg_o      = wreg_q;
  assign rs1_data_o  = rs1_data_q;
  assign rs2_data_o  = rs2_data_q;
  assign imm_o       = imm_q;
  assign pc_o        = pc_q;

endmodule
`default_nettype wire
